int2bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter (shift-add-3 / double dabble), one input bit per clock.

---
 rtl/int2bcd_if.sv | 23 ++
 rtl/int2bcd_seq.sv | 97 +++++++++
 tb/tb_int2bcd_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/int2bcd_if.sv
// Handshake/result bundle for the sequential binary-to-BCD converter.
//   start   : controller requests a conversion (honoured only while ready=1)
//   data_in : unsigned binary value, captured when start is accepted
//   ready   : converter idle, start accepted this cycle
//   done    : one-cycle pulse, data_h/data_l/ovf just updated
//   data_h  : tens digit (BCD)
//   data_l  : units digit (BCD)
//   ovf     : last converted value was above 99
// master = controller side, slave = converter side.
interface int2bcd_if #(
   parameter int IN_W = 7
);
   logic            start;
   logic [IN_W-1:0] data_in;
   logic            ready;
   logic            done;
   logic [3:0]      data_h;
   logic [3:0]      data_l;
   logic            ovf;

   modport master (output start, data_in, input ready, done, data_h, data_l, ovf);
   modport slave  (input start, data_in, output ready, done, data_h, data_l, ovf);
endinterface

// File: rtl/int2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Converts an IN_W-bit unsigned value into tens/units BCD digits plus an
// overflow flag for values above 99.
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : int2bcd_if slave port (start/data_in in, ready/done/data_h/data_l/ovf out)
// Timing: IDLE (accept) -> IN_W x SHIFT -> DONE (done=1) -> IDLE.
module int2bcd_seq #(
   parameter int IN_W = 7
) (
   input  logic      clk,
   input  logic      rst,
   int2bcd_if.slave  bus
);
   localparam int SR_W = 12 + IN_W;          // {hund, tens, units, bin}
   localparam int CW   = $clog2(IN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state, state_nxt;
   logic [SR_W-1:0] sr, sr_adj, sr_shl;
   logic [CW-1:0]   cnt;
   logic            last;
   logic            ready_c, done_c;
   logic [3:0]      data_h_q, data_l_q;
   logic            ovf_q;

   // Add-3 correction on every BCD nibble >= 5, then shift the whole register.
   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < 3; i++) begin
         if (sr[IN_W + 4*i +: 4] >= 4'd5)
            sr_adj[IN_W + 4*i +: 4] = sr[IN_W + 4*i +: 4] + 4'd3;
      end
   end

   assign sr_shl = {sr_adj[SR_W-2:0], 1'b0};
   assign last   = (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready_c   = 1'b0;
      done_c    = 1'b0;
      case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.start) state_nxt = SHIFT;
         end
         SHIFT: if (last) state_nxt = DONE;
         DONE: begin
            done_c    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr       <= '0;
         cnt      <= '0;
         data_h_q <= 4'd0;
         data_l_q <= 4'd0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               sr  <= {12'd0, bus.data_in};
               cnt <= CW'(IN_W);
            end
            SHIFT: begin
               sr  <= sr_shl;
               cnt <= cnt - CW'(1);
               // Results are taken from the final shifted value so they are
               // already stable during the DONE cycle.
               if (last) begin
                  data_l_q <= sr_shl[IN_W     +: 4];
                  data_h_q <= sr_shl[IN_W + 4 +: 4];
                  ovf_q    <= (sr_shl[IN_W + 8 +: 4] != 4'd0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready  = ready_c;
   assign bus.done   = done_c;
   assign bus.data_h = data_h_q;
   assign bus.data_l = data_l_q;
   assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_int2bcd_seq.sv
module tb_int2bcd_seq;
   localparam int IN_W = 7;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_h = 0, exp_l = 0, exp_o = 0;

   always #5 clk = ~clk;

   int2bcd_if #(.IN_W(IN_W)) bus ();
   int2bcd_seq #(.IN_W(IN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Reference: decimal digits by plain arithmetic.
   task automatic model(input int v);
      exp_h = (v / 10) % 10;
      exp_l = v % 10;
      exp_o = (v > 99) ? 1 : 0;
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, "_h"},   32'(bus.data_h), 32'(exp_h));
      chk({tag, "_l"},   32'(bus.data_l), 32'(exp_l));
      chk({tag, "_ovf"}, 32'(bus.ovf),    32'(exp_o));
   endtask

   task automatic wait_ready();
      int k;
      for (k = 0; k < 20 && !bus.ready; k++) @(negedge clk);
      if (k == 20) chk("ready_timeout", 0, 1);
   endtask

   // Full conversion with latency, busy, hold and pulse-width checks.
   task automatic run_conv(input int v);
      int  edges;
      bit  seen;
      logic [IN_W-1:0] d;
      d = v[IN_W-1:0];
      wait_ready();
      bus.start = 1'b1;
      bus.data_in = d;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.data_in = IN_W'($urandom);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         chk("busy_ready", 32'(bus.ready), 0);
         chk_outs("hold");
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      chk("done_seen", 32'(seen), 1);
      chk("latency", 32'(edges), 32'(IN_W + 1));
      model(v);
      chk_outs("result");
      chk("done_ready", 32'(bus.ready), 0);
      @(negedge clk);
      chk("done_width", 32'(bus.done), 0);
      chk("ready_after", 32'(bus.ready), 1);
   endtask

   initial begin
      int ndone;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.data_in = '0;

      // T1 reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(bus.ready), 1);
      chk("rst_done", 32'(bus.done), 0);
      chk_outs("rst");

      // T2 latency / T3 boundaries
      run_conv(59);
      run_conv(0);
      run_conv(99);
      run_conv(100);
      run_conv(127);

      // T4 start while busy is ignored, data_in changes ignored
      wait_ready();
      bus.start = 1'b1;
      bus.data_in = 7'd42;
      @(posedge clk);
      @(negedge clk);
      bus.data_in = 7'd13;
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("busy_single_done", 32'(ndone), 1);
      model(42);
      chk_outs("busy");

      // T5 reset on the 4th SHIFT cycle aborts
      bus.start = 1'b1;
      bus.data_in = 7'd88;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 32'(bus.ready), 1);
      chk("abort_done", 32'(bus.done), 0);
      model(0);
      chk_outs("abort");
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("abort_no_done", 32'(ndone), 0);
      run_conv(88);

      // rst and start in the same cycle: nothing accepted
      rst = 1'b1;
      bus.start = 1'b1;
      bus.data_in = 7'd77;
      @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b0;
      ndone = 0;
      chk("rs_ready", 32'(bus.ready), 1);
      repeat (12) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("rs_no_done", 32'(ndone), 0);
      model(0);
      chk_outs("rs");

      // T6 sweep, then random values
      for (int i = 0; i < 128; i++) run_conv(i);
      repeat (40) run_conv(int'($urandom_range(0, 127)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
